// File: rtl/pmem_line_responder.sv
// Line-granular backing store for the L1 cache's fill/write-back port.
// Each request completes after a fixed LATENCY, and only one request is in flight at a time.
module pmem_line_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [31:0]  pmem_address,
    input  logic [255:0] pmem_wdata,
    output logic         pmem_resp,
    output logic [255:0] pmem_rdata,
    output logic         busy,
    output logic         proto_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int         LINES     = 1 << INDEX_BITS;
    localparam logic [3:0] CNT_INIT  = 4'(LATENCY - 1);
    localparam bit         ONE_CYCLE = (LATENCY == 1);

    logic [1:0]             state;
    logic [3:0]             cnt;
    logic [LINES-1:0]       valid;

    logic                   op_write_p0;
    logic [INDEX_BITS-1:0]  idx_p0;
    logic [255:0]           wdata_p0;
    logic [255:0]           mem [LINES];

    logic                   req_one;
    logic                   req_both;
    logic                   accept;
    logic                   held_ok;
    logic                   opposite;
    logic                   abort;
    logic                   commit;
    logic                   commit_write;
    logic [INDEX_BITS-1:0]  req_idx;
    logic [INDEX_BITS-1:0]  commit_idx;
    logic [255:0]           commit_wdata;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^{pmem_address[4:0], pmem_address[31:5+INDEX_BITS]};

    // A commit happens on the edge that enters RESP; with LATENCY=1 that is the
    // accepting edge itself, so the live request fields are used instead of the latches.
    always_comb begin
        req_idx      = pmem_address[5 +: INDEX_BITS];
        req_one      = pmem_read ^ pmem_write;
        req_both     = pmem_read & pmem_write;
        accept       = (state == IDLE) && req_one;
        held_ok      = op_write_p0 ? pmem_write : pmem_read;
        opposite     = op_write_p0 ? pmem_read : pmem_write;
        abort        = (state == BUSY) && (!held_ok || opposite);
        commit       = !rst && ((accept && ONE_CYCLE) ||
                                ((state == BUSY) && !abort && (cnt == 4'd1)));
        commit_write = (state == IDLE) ? pmem_write : op_write_p0;
        commit_idx   = (state == IDLE) ? req_idx    : idx_p0;
        commit_wdata = (state == IDLE) ? pmem_wdata : wdata_p0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            valid      <= '0;
            proto_err  <= 1'b0;
            pmem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= CNT_INIT;
                        state <= ONE_CYCLE ? RESP : BUSY;
                    end else if (req_both) begin
                        proto_err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state <= IDLE;
                        if (opposite) proto_err <= 1'b1;
                    end else if (cnt == 4'd1) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                if (commit_write) valid[commit_idx] <= 1'b1;
                else pmem_rdata <= valid[commit_idx] ? mem[commit_idx] : '0;
            end
        end
    end

    // request latch and line store: data only, never reset
    always_ff @(posedge clk) begin
        if (accept) begin
            op_write_p0 <= pmem_write;
            idx_p0      <= req_idx;
            wdata_p0    <= pmem_wdata;
        end
        if (commit && commit_write) mem[commit_idx] <= commit_wdata;
    end

    assign pmem_resp = (state == RESP);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: directed vector table, randomized traffic against a
// line-array model, and hand-written abort / protocol-error / reset sequences.
module tb_pmem_line_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst  [2];
    logic         rd   [2];
    logic         wr   [2];
    logic [31:0]  addr [2];
    logic [255:0] wdat [2];
    logic         resp [2];
    logic         busy [2];
    logic         perr [2];
    logic [255:0] rdat [2];

    pmem_line_responder #(.LATENCY(4), .INDEX_BITS(6)) dut_a (
        .clk(clk), .rst(rst[0]), .pmem_read(rd[0]), .pmem_write(wr[0]),
        .pmem_address(addr[0]), .pmem_wdata(wdat[0]), .pmem_resp(resp[0]),
        .pmem_rdata(rdat[0]), .busy(busy[0]), .proto_err(perr[0])
    );

    pmem_line_responder #(.LATENCY(1), .INDEX_BITS(6)) dut_b (
        .clk(clk), .rst(rst[1]), .pmem_read(rd[1]), .pmem_write(wr[1]),
        .pmem_address(addr[1]), .pmem_wdata(wdat[1]), .pmem_resp(resp[1]),
        .pmem_rdata(rdat[1]), .busy(busy[1]), .proto_err(perr[1])
    );

    int total = 0;
    int bad   = 0;

    // reference model: one line array plus written flags per instance
    logic [255:0] rm [2][64];
    bit           rv [2][64];

    typedef struct {
        bit           w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] e;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic int lat(input int s);
        return (s == 0) ? 4 : 1;
    endfunction

    task automatic do_reset(input int s);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        rst[s] = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_resp", 256'(resp[s]), 256'd0);
        chk("rst_busy", 256'(busy[s]), 256'd0);
        chk("rst_perr", 256'(perr[s]), 256'd0);
        chk("rst_rdata", rdat[s], 256'd0);
        rst[s] = 1'b0;
        for (int i = 0; i < 64; i++) rv[s][i] = 1'b0;
    endtask

    // One request from the current cycle k; checks resp only at k+L, busy over k+1..k+L,
    // and rdata on the response. Returns at the start of cycle k+L+1 with lines dropped.
    task automatic txn(input int s, input bit w, input logic [31:0] a, input logic [255:0] d,
                       input bit use_exp, input logic [255:0] exp, input string nm);
        int           L;
        int           respcyc;
        int           nresp;
        int           busy_bad;
        logic [255:0] got;
        logic [255:0] want;
        logic [5:0]   idx;
        L        = lat(s);
        respcyc  = -1;
        nresp    = 0;
        busy_bad = 0;
        got      = '0;
        idx      = a[10:5];
        want     = use_exp ? exp : (rv[s][idx] ? rm[s][idx] : 256'd0);
        addr[s]  = a;
        wdat[s]  = d;
        wr[s]    = w;
        rd[s]    = !w;
        for (int j = 0; j <= L; j++) begin
            @(negedge clk);
            if (resp[s]) begin
                nresp++;
                respcyc = j;
                got = rdat[s];
            end
            if (busy[s] !== (j >= 1)) busy_bad++;
            @(posedge clk);
            #1;
        end
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        chk({nm, "_resp_cycle"}, 256'(respcyc), 256'(L));
        chk({nm, "_resp_count"}, 256'(nresp), 256'd1);
        chk({nm, "_busy_window"}, 256'(busy_bad), 256'd0);
        if (!w) chk({nm, "_rdata"}, got, want);
        else begin
            rm[s][idx] = d;
            rv[s][idx] = 1'b1;
        end
    endtask

    task automatic watch(input int s, input int n, output int nresp, output int nbusy);
        nresp = 0;
        nbusy = 0;
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            if (resp[s]) nresp++;
            if (busy[s]) nbusy++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [255:0] line_a5;
        logic [255:0] line_x;
        logic [255:0] line_z;
        logic [255:0] line_y;
        logic [255:0] rnd;
        logic [31:0]  ra;
        int           nr;
        int           nb;

        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; rd[s] = 1'b0; wr[s] = 1'b0;
            addr[s] = '0; wdat[s] = '0;
        end
        line_a5 = {32{8'hA5}};
        line_x  = {8{32'hDEAD_BEEF}};
        line_z  = {16{16'h1234}};
        line_y  = {8{32'h0BAD_F00D}};

        tbl[0] = '{w: 1'b0, a: 32'h0000_0060, d: '0,      e: '0};
        tbl[1] = '{w: 1'b1, a: 32'h0000_0040, d: line_a5, e: '0};
        tbl[2] = '{w: 1'b0, a: 32'h0000_0040, d: '0,      e: line_a5};
        tbl[3] = '{w: 1'b1, a: 32'h0000_00A0, d: line_x,  e: '0};
        tbl[4] = '{w: 1'b0, a: 32'h0000_0120, d: '0,      e: '0};
        tbl[5] = '{w: 1'b0, a: 32'h0000_00A0, d: '0,      e: line_x};
        tbl[6] = '{w: 1'b0, a: 32'h0000_0840, d: '0,      e: line_a5};
        tbl[7] = '{w: 1'b1, a: 32'h0000_7FE0, d: line_z,  e: '0};
        tbl[8] = '{w: 1'b0, a: 32'hFFFF_0FFF, d: '0,      e: line_z};

        do_reset(0);
        do_reset(1);
        repeat (8) @(posedge clk);
        #1;

        // back-to-back directed vectors on the LATENCY=4 instance
        for (int i = 0; i < 9; i++)
            txn(0, tbl[i].w, tbl[i].a, tbl[i].d, !tbl[i].w, tbl[i].e, $sformatf("vec%0d", i));

        // randomized traffic over a few indices with aliasing upper address bits
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
            ra = $urandom;
            ra[10:5] = 6'($urandom_range(0, 7));
            txn(0, 1'($urandom_range(0, 1)), ra, rnd, 1'b0, '0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // write dropped after two BUSY cycles: silent abort, old line kept
        txn(0, 1'b1, 32'h0000_00E0, line_z, 1'b0, '0, "abort_pre");
        addr[0] = 32'h0000_00E0; wdat[0] = line_y; wr[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wr[0] = 1'b0;
        watch(0, 7, nr, nb);
        chk("abort_drop_resp", 256'(nr), 256'd0);
        chk("abort_drop_perr", 256'(perr[0]), 256'd0);
        chk("abort_drop_busy", 256'(busy[0]), 256'd0);
        txn(0, 1'b0, 32'h0000_00E0, '0, 1'b1, line_z, "abort_drop_rd");

        // read raised during a write: abort with sticky protocol error
        addr[0] = 32'h0000_00E0; wdat[0] = line_y; wr[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rd[0] = 1'b1;
        @(posedge clk); #1;
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        watch(0, 6, nr, nb);
        chk("abort_opp_resp", 256'(nr), 256'd0);
        chk("abort_opp_perr", 256'(perr[0]), 256'd1);
        txn(0, 1'b0, 32'h0000_00E0, '0, 1'b1, line_z, "abort_opp_rd");
        chk("perr_sticky", 256'(perr[0]), 256'd1);

        // both request lines high in IDLE
        do_reset(0);
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h0000_0040;
        watch(0, 3, nr, nb);
        rd[0] = 1'b0; wr[0] = 1'b0;
        watch(0, 2, nr, nb);
        chk("both_resp", 256'(nr), 256'd0);
        chk("both_busy", 256'(nb), 256'd0);
        chk("both_perr", 256'(perr[0]), 256'd1);

        // asynchronous reset while a write is in flight
        do_reset(0);
        txn(0, 1'b1, 32'h0000_0020, line_x, 1'b0, '0, "rstmid_wr1");
        txn(0, 1'b0, 32'h0000_0020, '0, 1'b1, line_x, "rstmid_rd1");
        addr[0] = 32'h0000_0040; wdat[0] = line_a5; wr[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst[0] = 1'b1;
        #1;
        chk("rstmid_resp", 256'(resp[0]), 256'd0);
        chk("rstmid_busy", 256'(busy[0]), 256'd0);
        chk("rstmid_rdata", rdat[0], 256'd0);
        chk("rstmid_perr", 256'(perr[0]), 256'd0);
        wr[0] = 1'b0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        for (int i = 0; i < 64; i++) rv[0][i] = 1'b0;
        txn(0, 1'b0, 32'h0000_0040, '0, 1'b1, 256'd0, "rstmid_rd2");
        txn(0, 1'b0, 32'h0000_0020, '0, 1'b1, 256'd0, "rstmid_rd3");

        // LATENCY=1 instance: response in the cycle after acceptance
        txn(1, 1'b1, 32'h0000_0040, line_y, 1'b0, '0, "l1_wr");
        txn(1, 1'b0, 32'h0000_0080, '0, 1'b1, 256'd0, "l1_rd_unwritten");
        txn(1, 1'b0, 32'h0000_0040, '0, 1'b1, line_y, "l1_rd");
        do_reset(1);
        txn(1, 1'b0, 32'h0000_0040, '0, 1'b1, 256'd0, "l1_rd_after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
